// File: rtl/unidad_logica_seq.sv
// unidad_logica_seq: registered one-hot logic unit with a valid/ready output stage
// and a saturating count of legal operations.
module unidad_logica_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_onehot,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             op_err,
  output logic [CNT_W-1:0] op_count,
  input  logic             clr_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic zero_q, err_q, legal, xfer;
  assign in_ready = (state_q == EMPTY) || out_ready;
  always_comb begin
    legal = (op_onehot != 4'b0) && ((op_onehot & (op_onehot - 4'd1)) == 4'b0);
    result_d = !legal ? '0 :
               op_onehot[0] ? op_a & op_b :
               op_onehot[1] ? op_a | op_b :
               op_onehot[2] ? ~(op_a & op_b) : op_a ^ op_b;
    xfer = in_valid && in_ready;
    // clear wins over a coincident increment; the count sticks at all-ones
    cnt_d = clr_count ? '0 : (xfer && legal && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (xfer) begin
        state_q  <= FULL;
        result_q <= result_d;
        zero_q   <= (result_d == '0);
        err_q    <= !legal;
      end else if (out_ready) begin
        state_q <= EMPTY;
      end
    end
  end
  assign out_valid = (state_q == FULL);
  assign result    = result_q;
  assign zero      = zero_q;
  assign op_err    = err_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_unidad_logica_seq.sv
// tb_unidad_logica_seq: directed vectors against an 8-bit-counter instance and a
// 2-bit-counter instance, checked every cycle against a behavioural model.
module tb_unidad_logica_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0;
  logic [3:0] op_onehot = 4'b0;
  logic [7:0] op_a = 8'h0, op_b = 8'h0;
  logic in_ready, out_valid, zero, op_err;
  logic [7:0] result, op_count;
  logic in_ready2, out_valid2, zero2, op_err2;
  logic [7:0] result2;
  logic [1:0] op_count2;
  int checks = 0, failures = 0;
  logic m_valid = 1'b0, m_zero = 1'b0, m_err = 1'b0;
  logic [7:0] m_res = 8'h0;
  int m_cnt8 = 0, m_cnt2 = 0;
  logic [7:0] held;

  always #5 clk = ~clk;

  unidad_logica_seq #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_onehot(op_onehot), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .op_err(op_err),
    .op_count(op_count), .clr_count(clr_count));

  unidad_logica_seq #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op_onehot(op_onehot), .op_a(op_a), .op_b(op_b), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .zero(zero2), .op_err(op_err2),
    .op_count(op_count2), .clr_count(clr_count));

  function automatic logic [7:0] model_op(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] tbl [4];
    tbl[0] = a & b;
    tbl[1] = a | b;
    tbl[2] = ~(a & b);
    tbl[3] = a ^ b;
    return ($countones(op) == 1) ? tbl[$clog2(op)] : 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_res <= 8'h0; m_zero <= 1'b0; m_err <= 1'b0;
      m_cnt8 <= 0; m_cnt2 <= 0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_res  <= model_op(op_onehot, op_a, op_b);
        m_zero <= model_op(op_onehot, op_a, op_b) == 8'h0;
        m_err  <= $countones(op_onehot) != 1;
      end
      m_valid <= (in_valid && (!m_valid || out_ready)) || (m_valid && !out_ready);
      if (clr_count) begin
        m_cnt8 <= 0; m_cnt2 <= 0;
      end else if (in_valid && (!m_valid || out_ready) && $countones(op_onehot) == 1) begin
        m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("result", 32'(result), 32'(m_res));
    chk("zero", 32'(zero), 32'(m_zero));
    chk("op_err", 32'(op_err), 32'(m_err));
    chk("op_count", 32'(op_count), 32'(m_cnt8));
    chk("op_count2", 32'(op_count2), 32'(m_cnt2));
    chk("result2", 32'(result2), 32'(m_res));
    chk("out_valid2", 32'(out_valid2), 32'(m_valid));
  end

  task automatic cyc(input logic v, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic r, input logic c);
    in_valid = v; op_onehot = op; op_a = a; op_b = b; out_ready = r; clr_count = c;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("lit reset in_ready", 32'(in_ready), 32'd1);
    chk("lit reset out_valid", 32'(out_valid), 32'd0);
    cyc(1, 4'b0001, 8'hCC, 8'hAA, 1, 0);
    chk("lit and", 32'(result), 32'h88);
    chk("lit and valid", 32'(out_valid), 32'd1);
    cyc(1, 4'b0010, 8'hCC, 8'hAA, 1, 0);
    chk("lit or", 32'(result), 32'hEE);
    cyc(1, 4'b0100, 8'hCC, 8'hAA, 1, 0);
    chk("lit nand", 32'(result), 32'h77);
    cyc(1, 4'b1000, 8'hCC, 8'hAA, 1, 0);
    chk("lit xor", 32'(result), 32'h66);
    chk("lit count4", 32'(op_count), 32'd4);
    chk("lit count4 sat", 32'(op_count2), 32'd3);
    cyc(1, 4'b0001, 8'hF0, 8'h0F, 1, 0);
    chk("lit zero res", 32'(result), 32'h00);
    chk("lit zero flag", 32'(zero), 32'd1);
    chk("lit zero err", 32'(op_err), 32'd0);
    cyc(1, 4'b0000, 8'hFF, 8'hFF, 1, 0);
    chk("lit ill0 err", 32'(op_err), 32'd1);
    chk("lit ill0 zero", 32'(zero), 32'd1);
    cyc(1, 4'b0110, 8'hFF, 8'hFF, 1, 0);
    chk("lit ill6 err", 32'(op_err), 32'd1);
    chk("lit ill6 res", 32'(result), 32'h00);
    chk("lit ill count", 32'(op_count), 32'd5);
    cyc(0, 4'b0001, 8'hFF, 8'hFF, 1, 0);
    chk("lit drain", 32'(out_valid), 32'd0);
    chk("lit hold res", 32'(result), 32'h00);
    // backpressure
    cyc(1, 4'b0010, 8'h12, 8'h40, 0, 0);
    held = result;
    chk("lit bp load", 32'(held), 32'h52);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'(1 << (i % 4)), 8'(i * 37), 8'(i * 91), 0, 0);
      chk("lit bp ready", 32'(in_ready), 32'd0);
      chk("lit bp stable", 32'(result), 32'(held));
    end
    cyc(1, 4'b1000, 8'h0F, 8'h3C, 1, 0);
    chk("lit bp release", 32'(result), 32'h33);
    chk("lit bp valid", 32'(out_valid), 32'd1);
    // throughput with a cleared counter
    cyc(0, 4'b0001, 8'h00, 8'h00, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 4'(1 << (i % 4)), 8'(i * 29 + 3), 8'(i * 53 + 7), 1, 0);
      chk("lit tput valid", 32'(out_valid), 32'd1);
    end
    chk("lit count10", 32'(op_count), 32'd10);
    chk("lit count10 sat", 32'(op_count2), 32'd3);
    cyc(1, 4'b0001, 8'hFF, 8'hFF, 1, 1);
    chk("lit clr wins", 32'(op_count), 32'd0);
    chk("lit clr wins2", 32'(op_count2), 32'd0);
    // reset in the middle of a stalled transfer
    cyc(1, 4'b0010, 8'h81, 8'h18, 0, 0);
    chk("lit pre-rst valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("lit rst valid", 32'(out_valid), 32'd0);
    chk("lit rst res", 32'(result), 32'd0);
    chk("lit rst count", 32'(op_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("lit post-rst ready", 32'(in_ready), 32'd1);
    cyc(0, 4'b0001, 8'hFF, 8'hFF, 0, 0);
    chk("lit no spurious", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
